// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the 5-stage pipeline.
//
// Generates per-stage write enables, the IF/ID flush and the ID/EX bubble.
// Sources are load-use stalls, taken branches resolved in ID, instruction and
// data memory wait states, and a debug halt/step interface. It also keeps
// saturating performance counters.
//
// State | meaning
// ------+-----------------------------------------------------------------
// RUN   | normal issue; stall/branch/freeze rules applied every cycle
// WAIT  | memory not ready: full freeze until ready, then RUN rules again
// DRAIN | halt requested: bubbles pushed into ID/EX to empty the back end
// HALT  | core quiesced, all enables low, waiting for step or release
// STEP  | exactly one cycle of RUN rules issued from HALT
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   id_stall, id_branch       hazard/branch indications from ID
//   imem_req/imem_ready       instruction fetch handshake
//   dmem_req/dmem_ready       data memory handshake
//   dbg_halt (level)          debug halt request
//   dbg_step (pulse)          debug single step, only honoured in HALT
//   pc_we, ifid_we, exmem_we, memwb_we   stage write enables
//   ifid_flush, idex_bubble   squash controls
//   halted                    high while in HALT
//   mem_err                   sticky memory timeout flag
//   stall_cnt, flush_cnt, wait_cnt       saturating performance counters
module pipe_ctrl #(
  parameter int CNT_W     = 16,
  parameter int DRAIN_CYC = 3,
  parameter int WAIT_MAX  = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_stall,
  input  logic             id_branch,
  input  logic             imem_req,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             dbg_halt,
  input  logic             dbg_step,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam int TW = $clog2(WAIT_MAX + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);
  localparam logic [TW-1:0] WAIT_MAX_V = TW'(WAIT_MAX);

  typedef enum logic [2:0] {
    S_RUN   = 3'd0,
    S_WAIT  = 3'd1,
    S_DRAIN = 3'd2,
    S_HALT  = 3'd3,
    S_STEP  = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   drain_cnt, drain_nxt;
  logic [TW-1:0]   wait_tmr;
  logic            ret_halt, ret_nxt;
  logic            mem_busy;
  logic            busy_frz;
  logic            stall_inc;
  logic            flush_inc;

  assign mem_busy = (imem_req & ~imem_ready) | (dmem_req & ~dmem_ready);
  assign halted   = (state == S_HALT);

  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_we    = 1'b0;
    memwb_we    = 1'b0;
    state_nxt   = state;
    drain_nxt   = drain_cnt;
    ret_nxt     = ret_halt;
    busy_frz    = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    case (state)
      S_RUN, S_WAIT, S_STEP: begin
        if (mem_busy) begin
          busy_frz  = 1'b1;
          state_nxt = S_WAIT;
          // Remember that this freeze began from a single step.
          ret_nxt   = ret_halt | (state == S_STEP);
        end else begin
          if (id_stall) begin
            // Branch operands are not valid during a load-use stall.
            idex_bubble = 1'b1;
            exmem_we    = 1'b1;
            memwb_we    = 1'b1;
            stall_inc   = 1'b1;
          end else begin
            pc_we    = 1'b1;
            ifid_we  = 1'b1;
            exmem_we = 1'b1;
            memwb_we = 1'b1;
            if (id_branch) begin
              ifid_flush = 1'b1;
              flush_inc  = 1'b1;
            end
          end
          ret_nxt = 1'b0;
          if (ret_halt || (state == S_STEP)) begin
            state_nxt = S_HALT;
          end else if (dbg_halt && !id_stall) begin
            // A halt request waits out stalls; a branch cycle still flushes
            // normally and draining begins right after it.
            state_nxt = S_DRAIN;
            drain_nxt = '0;
          end else begin
            state_nxt = S_RUN;
          end
        end
      end
      S_DRAIN: begin
        if (mem_busy) begin
          busy_frz = 1'b1;
        end else begin
          idex_bubble = 1'b1;
          exmem_we    = 1'b1;
          memwb_we    = 1'b1;
          if (drain_cnt == DRAIN_LAST) begin
            state_nxt = S_HALT;
            drain_nxt = '0;
          end else begin
            drain_nxt = drain_cnt + 1'b1;
          end
        end
      end
      S_HALT: begin
        if (dbg_step) begin
          state_nxt = S_STEP;
        end else if (!dbg_halt) begin
          state_nxt = S_RUN;
        end
      end
      default: begin
        state_nxt = S_RUN;
      end
    endcase

    if (rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      exmem_we    = 1'b0;
      memwb_we    = 1'b0;
      busy_frz    = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      drain_cnt <= '0;
      wait_tmr  <= '0;
      ret_halt  <= 1'b0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      ret_halt  <= ret_nxt;
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      if (busy_frz) begin
        if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
        // Timer counts consecutive frozen-on-memory cycles and saturates.
        if (wait_tmr != WAIT_MAX_V) wait_tmr <= wait_tmr + 1'b1;
        if (wait_tmr >= (WAIT_MAX_V - 1'b1)) mem_err <= 1'b1;
      end else begin
        wait_tmr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  localparam int CNT_W     = 4;
  localparam int DRAIN_CYC = 3;
  localparam int WAIT_MAX  = 3;
  localparam int CMAX      = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_stall = 1'b0, id_branch = 1'b0;
  logic imem_req = 1'b0, imem_ready = 1'b0;
  logic dmem_req = 1'b0, dmem_ready = 1'b0;
  logic dbg_halt = 1'b0, dbg_step = 1'b0;
  logic pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we;
  logic halted, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;

  pipe_ctrl #(.CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst),
    .id_stall(id_stall), .id_branch(id_branch),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .dbg_halt(dbg_halt), .dbg_step(dbg_step),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .exmem_we(exmem_we), .memwb_we(memwb_we),
    .halted(halted), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // {pc, ifid, flush, bubble, exmem, memwb, halted, mem_err}
  wire [7:0] obs = {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we, halted, mem_err};
  wire [3*CNT_W-1:0] obs_cnt = {stall_cnt, flush_cnt, wait_cnt};

  // Reference model: "halted", "draining N more bubbles", "single step pending",
  // "return to halt after the memory wait", and a run-length of frozen cycles.
  bit m_halt, m_step, m_ret, m_err;
  int m_drain, m_run, m_sc, m_fc, m_wc;
  bit n_halt, n_step, n_ret, n_err;
  int n_drain, n_run, n_sc, n_fc, n_wc;
  logic [7:0] exp_o;

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic logic [3*CNT_W-1:0] exp_cnt();
    return {CNT_W'(m_sc), CNT_W'(m_fc), CNT_W'(m_wc)};
  endfunction

  task automatic model_reset();
    m_halt = 0; m_step = 0; m_ret = 0; m_err = 0;
    m_drain = 0; m_run = 0; m_sc = 0; m_fc = 0; m_wc = 0;
  endtask

  task automatic model_eval();
    bit busy, frz;
    busy = (imem_req && !imem_ready) || (dmem_req && !dmem_ready);
    frz = 0;
    n_halt = m_halt; n_step = m_step; n_ret = m_ret; n_err = m_err;
    n_drain = m_drain; n_run = m_run; n_sc = m_sc; n_fc = m_fc; n_wc = m_wc;
    exp_o = {6'b0, m_halt, m_err};
    if (rst) begin
      n_halt = 0; n_step = 0; n_ret = 0; n_err = 0;
      n_drain = 0; n_run = 0; n_sc = 0; n_fc = 0; n_wc = 0;
    end else if (m_halt) begin
      n_run = 0;
      if (dbg_step) begin n_halt = 0; n_step = 1; end
      else if (!dbg_halt) n_halt = 0;
    end else if (m_drain > 0) begin
      if (busy) frz = 1;
      else begin
        exp_o[7:2] = 6'b000111;
        n_drain = m_drain - 1;
        if (n_drain == 0) n_halt = 1;
      end
    end else begin
      if (busy) begin
        frz = 1;
        n_ret = m_ret | m_step;
        n_step = 0;
      end else begin
        if (id_stall) begin
          exp_o[7:2] = 6'b000111;
          n_sc = sat(m_sc);
        end else if (id_branch) begin
          exp_o[7:2] = 6'b111011;
          n_fc = sat(m_fc);
        end else begin
          exp_o[7:2] = 6'b110011;
        end
        n_step = 0; n_ret = 0;
        if (m_step || m_ret) n_halt = 1;
        else if (dbg_halt && !id_stall) n_drain = DRAIN_CYC;
      end
    end
    if (frz) begin
      n_wc = sat(m_wc);
      n_run = m_run + 1;
      if (n_run >= WAIT_MAX) n_err = 1;
    end else if (!rst) begin
      n_run = 0;
    end
  endtask

  task automatic model_advance();
    m_halt = n_halt; m_step = n_step; m_ret = n_ret; m_err = n_err;
    m_drain = n_drain; m_run = n_run; m_sc = n_sc; m_fc = n_fc; m_wc = n_wc;
  endtask

  // Apply inputs after the falling edge, then compute expected outputs.
  task automatic drive(input logic r, input logic st, input logic br,
                       input logic iq, input logic iy, input logic dq,
                       input logic dy, input logic hl, input logic sp);
    @(negedge clk);
    rst = r; id_stall = st; id_branch = br;
    imem_req = iq; imem_ready = iy; dmem_req = dq; dmem_ready = dy;
    dbg_halt = hl; dbg_step = sp;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
  endtask

  task automatic test_reset();
    model_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs[7:2] !== 6'b0) begin
      errors++; $display("FAIL reset_we obs=%b exp=000000", obs[7:2]);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 8'b1100_1100) begin
      errors++; $display("FAIL reset_idle obs=%b exp=11001100", obs);
    end
    checks++;
    if (obs_cnt !== '0) begin
      errors++; $display("FAIL reset_cnt obs=%h exp=0", obs_cnt);
    end
    tick();
  endtask

  task automatic test_stall();
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 8'b0001_1100) begin
      errors++; $display("FAIL stall_out obs=%b exp=00011100", obs);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (stall_cnt !== 4'd1 || flush_cnt !== 4'd0) begin
      errors++; $display("FAIL stall_cnt stall=%0d flush=%0d exp 1 0", stall_cnt, flush_cnt);
    end
    tick();
  endtask

  task automatic test_branch();
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 8'b1110_1100) begin
      errors++; $display("FAIL branch_out obs=%b exp=11101100", obs);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (flush_cnt !== 4'd1) begin
      errors++; $display("FAIL branch_cnt obs=%0d exp=1", flush_cnt);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
      checks++;
      if (obs[7:2] !== 6'b0) begin
        errors++; $display("FAIL wait_freeze cyc=%0d obs=%b exp=000000", i, obs[7:2]);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
    checks++;
    if (obs !== 8'b1100_1101) begin
      errors++; $display("FAIL wait_resume obs=%b exp=11001101", obs);
    end
    checks++;
    if (wait_cnt !== 4'd4) begin
      errors++; $display("FAIL wait_cnt obs=%0d exp=4", wait_cnt);
    end
    tick();
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick(); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (mem_err !== 1'b1) begin
      errors++; $display("FAIL mem_err_sticky obs=%b exp=1", mem_err);
    end
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (mem_err !== 1'b0) begin
      errors++; $display("FAIL mem_err_clear obs=%b exp=0", mem_err);
    end
    tick();
  endtask

  task automatic test_halt_step();
    logic [7:0] want [0:8];
    logic       hl   [0:8];
    logic       sp   [0:8];
    // RUN, 3x DRAIN, HALT, HALT(step seen), STEP, HALT(release seen), RUN
    want = '{8'b1100_1100, 8'b0001_1100, 8'b0001_1100, 8'b0001_1100,
             8'b0000_0010, 8'b0000_0010, 8'b1100_1100, 8'b0000_0010, 8'b1100_1100};
    hl   = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    sp   = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, hl[i], sp[i]);
      checks++;
      if (obs !== want[i]) begin
        errors++; $display("FAIL halt_seq cyc=%0d obs=%b exp=%b", i, obs, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin drive(0, 1, 0, 0, 0, 0, 0, 0, 0); tick(); end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (stall_cnt !== 4'd15) begin
      errors++; $display("FAIL stall_sat obs=%0d exp=15", stall_cnt);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (obs[7:2] !== 6'b0) begin
      errors++; $display("FAIL rst_drain_we obs=%b exp=000000", obs[7:2]);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 8'b1100_1100 || obs_cnt !== '0) begin
      errors++; $display("FAIL rst_drain obs=%b cnt=%h exp=11001100 cnt=0", obs, obs_cnt);
    end
    tick();
  endtask

  task automatic test_random();
    logic hl;
    hl = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 8) hl = ~hl;
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 50,
            hl, $urandom_range(0, 99) < 15);
      checks++;
      if (rst ? (obs[7:2] !== exp_o[7:2]) : (obs !== exp_o)) begin
        errors++; $display("FAIL rand_out cyc=%0d obs=%b exp=%b", i, obs, exp_o);
      end
      checks++;
      if (obs_cnt !== exp_cnt()) begin
        errors++; $display("FAIL rand_cnt cyc=%0d obs=%h exp=%h", i, obs_cnt, exp_cnt());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_branch();
    test_mem_wait();
    test_halt_step();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
